// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift sequencer: FSM state codes, shift modes,
// register command codes and the shift-count clamp helper.
package shift_seq_pkg;

  localparam int unsigned MAX_AMT_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] LOGICAL = 2'd0;
  localparam logic [1:0] ARITH   = 2'd1;
  localparam logic [1:0] ROTATE  = 2'd2;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_LOAD  = 2'b11;

  function automatic logic [3:0] clamp_amt(input logic [3:0] amt, input logic [3:0] max_amt);
    return (amt > max_amt) ? max_amt : amt;
  endfunction

endpackage

// File: rtl/shift_count.sv
// 4-bit loadable down-counter with a zero flag; decrementing stops at zero.
module shift_count (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic [3:0] o_count,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 4'd0);

endmodule

// File: rtl/shift_sequencer.sv
// Command-side controller for an 8-bit shift register: load, N shifts, result.
// Define SHIFT_SEQ_ROTATE_EN to enable rotate mode; otherwise mode 2 fills with 0.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_AMT = MAX_AMT_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [1:0]       req_mode,
  input  logic [3:0]       req_amount,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] reg_load_data,
  output logic [1:0]       reg_shift,
  output logic             reg_d0,
  output logic             reg_load_d0,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             busy
);

  localparam logic [3:0] MaxAmtL = 4'(MAX_AMT);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic             r_carry;
  logic             w_accept;
  logic [3:0]       w_count;
  logic             w_count_zero;
  logic             w_fill;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  shift_count u_shift_count (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_accept),
    .i_load_val (clamp_amt(req_amount, MaxAmtL)),
    .i_dec      (r_state == ST_SHIFT),
    .o_count    (w_count),
    .o_zero     (w_count_zero)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = w_count_zero ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (w_count == 4'd1) w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_mode  <= LOGICAL;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data  <= req_data;
        r_dir   <= req_dir;
        r_mode  <= req_mode;
        r_carry <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
        r_carry <= r_dir ? reg_q[WIDTH-1] : reg_q[0];
      end
    end
  end

  // Fill bit follows the register's live Q so each step sees the previous shift.
  always_comb begin
    w_fill = 1'b0;
    case (r_mode)
      ARITH:   w_fill = ~r_dir & reg_q[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      ROTATE:  w_fill = r_dir ? reg_q[WIDTH-1] : reg_q[0];
`else
      ROTATE:  w_fill = 1'b0;
`endif
      default: w_fill = 1'b0;
    endcase
  end

  always_comb begin
    reg_shift = SH_HOLD;
    case (r_state)
      ST_LOAD:  reg_shift = SH_LOAD;
      ST_SHIFT: reg_shift = r_dir ? SH_LEFT : SH_RIGHT;
      default:  reg_shift = SH_HOLD;
    endcase
  end

  assign reg_load_data = (r_state == ST_LOAD) ? r_data : '0;
  assign reg_d0        = (r_state == ST_SHIFT) ? w_fill : 1'b0;
  assign reg_load_d0   = 1'b0;
  assign req_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign res_valid     = (r_state == ST_DONE);
  assign res_data      = (r_state == ST_DONE) ? reg_q : '0;
  assign res_carry     = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shift register on reg_q, scoreboard of
// expected results pushed at acceptance and popped on res_valid.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit Rot = 1'b1;
`else
  localparam bit Rot = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_data = 8'h00;
  logic       req_dir = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic [3:0] req_amount = 4'd0;
  logic [7:0] reg_q = 8'h00;
  logic [7:0] reg_load_data;
  logic [1:0] reg_shift;
  logic       reg_d0;
  logic       reg_load_d0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       busy;

  shift_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .req_dir       (req_dir),
    .req_mode      (req_mode),
    .req_amount    (req_amount),
    .reg_q         (reg_q),
    .reg_load_data (reg_load_data),
    .reg_shift     (reg_shift),
    .reg_d0        (reg_d0),
    .reg_load_d0   (reg_load_d0),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_carry     (res_carry),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The shift register the sequencer commands.
  always @(posedge clk) begin
    case (reg_shift)
      2'b11:   reg_q <= reg_load_data;
      2'b01:   reg_q <= {reg_d0, reg_q[7:1]};
      2'b10:   reg_q <= {reg_q[6:0], reg_d0};
      default: reg_q <= reg_q;
    endcase
  end

  typedef struct {
    logic [7:0] data;
    logic       carry;
    int         acc_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails = 0;
  int   n_res = 0;
  int   last_res_cyc = -1;
  int   last_acc_cyc = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] d, input logic dir,
                                       input logic [1:0] mode, input logic [3:0] amt);
    logic [7:0] q;
    logic       c;
    logic       f;
    int         eff;
    q   = d;
    c   = 1'b0;
    eff = (amt > 4'd8) ? 8 : int'(amt);
    for (int i = 0; i < eff; i++) begin
      if (!dir) begin
        f = (mode == 2'd1) ? q[7] : ((mode == 2'd2 && Rot) ? q[0] : 1'b0);
        c = q[0];
        q = {f, q[7:1]};
      end else begin
        f = (mode == 2'd2 && Rot) ? q[7] : 1'b0;
        c = q[7];
        q = {q[6:0], f};
      end
    end
    return {c, q};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && res_valid) begin
      n_res++;
      last_res_cyc = cyc;
      if (sb.size() == 0) begin
        check_val("res_spurious", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("res_data", res_data, e.data);
        check_val("res_carry", res_carry, e.carry);
        check_val("res_latency", cyc - e.acc_cyc, e.lat);
        check_val("res_busy", busy, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send_req(input logic [7:0] d, input logic dir, input logic [1:0] mode,
                          input logic [3:0] amt);
    int         budget;
    int         eff;
    logic [8:0] m;
    budget     = 0;
    req_valid  = 1'b1;
    req_data   = d;
    req_dir    = dir;
    req_mode   = mode;
    req_amount = amt;
    while (!req_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    eff = (amt > 4'd8) ? 8 : int'(amt);
    m   = model(d, dir, mode, amt);
    sb.push_back('{data: m[7:0], carry: m[8], acc_cyc: cyc, lat: eff + 2});
    last_acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      check_val("result_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_busy"}, busy, 0);
    check_val({phase, "_res_valid"}, res_valid, 0);
    check_val({phase, "_res_data"}, res_data, 8'h00);
    check_val({phase, "_res_carry"}, res_carry, 0);
    check_val({phase, "_reg_shift"}, reg_shift, 2'b00);
    check_val({phase, "_reg_d0"}, reg_d0, 0);
    check_val({phase, "_reg_load_data"}, reg_load_data, 8'h00);
    check_val({phase, "_reg_load_d0"}, reg_load_d0, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int saved_res;
    // Request already present while reset is held.
    req_valid  = 1'b1;
    req_data   = 8'h96;
    req_amount = 4'd3;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    #1;
    check_val("rel_ready", req_ready, 1);
    check_val("rel_busy", busy, 0);
    @(negedge clk);
    check_val("rel_accepted_first_edge", busy, 1);
    req_valid = 1'b0;
    sb.push_back('{data: 8'h12, carry: 1'b1, acc_cyc: cyc - 1, lat: 5});
    wait_idle();

    send_req(8'h96, 1'b0, 2'd0, 4'd3); wait_idle();
    send_req(8'h96, 1'b0, 2'd1, 4'd2); wait_idle();
    send_req(8'h96, 1'b1, 2'd2, 4'd3); wait_idle();
    send_req(8'h96, 1'b0, 2'd2, 4'd3); wait_idle();
    send_req(8'h96, 1'b0, 2'd3, 4'd2); wait_idle();
    send_req(8'h5A, 1'b0, 2'd0, 4'd0); wait_idle();
    send_req(8'h5A, 1'b1, 2'd0, 4'd12); wait_idle();
    send_req(8'h81, 1'b0, 2'd1, 4'd15); wait_idle();

    // Back-to-back with req_valid held high across the first operation.
    send_req(8'hA5, 1'b0, 2'd1, 4'd3);
    req_valid  = 1'b1;
    req_data   = 8'h3C;
    req_dir    = 1'b1;
    req_mode   = 2'd2;
    req_amount = 4'd2;
    for (int i = 0; i < 5; i++) begin
      check_val("b2b_ready_low", req_ready, 0);
      @(negedge clk);
    end
    send_req(8'h3C, 1'b1, 2'd2, 4'd2);
    check_val("b2b_accept_cycle", last_acc_cyc, last_res_cyc + 1);
    wait_idle();

    // Reset in the middle of a 7-step shift.
    send_req(8'hC3, 1'b0, 2'd1, 4'd7);
    @(negedge clk);
    check_val("mid_busy_before_rst", busy, 1);
    check_val("mid_shift_cmd", reg_shift, 2'b01);
    saved_res = n_res;
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort_no_res", n_res, saved_res);
    send_req(8'hC3, 1'b0, 2'd1, 4'd7); wait_idle();

    for (int i = 0; i < 16; i++) begin
      send_req(8'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
